// File: rtl/stream_muxn_rr.sv
// N-channel registered stream mux with round-robin or fixed-priority arbitration
// and optional packet lock that holds the grant from first beat to last beat.
//
// state     | meaning
// ST_OPEN   | no packet in flight; grant comes from arbitration over valid channels
// ST_LOCKED | packet in flight on channel lk_q; only that channel may be granted
module stream_muxn_rr #(
  parameter int n    = 16,
  parameter int N_CH = 4,
  parameter int RR   = 1,
  parameter int LOCK = 1,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*n-1:0]   in_data,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH-1:0]     in_last,
  output logic [N_CH-1:0]     in_ready,
  output logic [n-1:0]        out_data,
  output logic                out_last,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  localparam logic [SEL_W:0]   NCH_W   = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH-1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] lk_q, lk_d, ptr_q, ptr_d, gsel;
  logic [SEL_W:0]   sum;
  logic [N_CH-1:0]  grant;
  logic             found, load, xfer, last_eff;
  logic [n-1:0]     ch_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*n +: n];
  end

  assign load     = !out_valid || out_ready;
  assign xfer     = |grant;
  assign in_ready = grant;
  assign last_eff = (LOCK != 0) ? in_last[gsel] : 1'b1;

  // Search order starts at ptr_q for round-robin, at 0 for fixed priority.
  always_comb begin
    grant = '0;
    gsel  = '0;
    sum   = '0;
    found = 1'b0;
    if (load && rst_n) begin
      if (LOCK != 0 && state_q == ST_LOCKED) begin
        gsel        = lk_q;
        grant[lk_q] = in_valid[lk_q];
      end else begin
        for (int k = 0; k < N_CH; k++) begin
          if (RR != 0) sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
          else         sum = (SEL_W+1)'(k);
          if (sum >= NCH_W) sum = sum - NCH_W;
          if (!found && in_valid[sum[SEL_W-1:0]]) begin
            found = 1'b1;
            gsel  = sum[SEL_W-1:0];
          end
        end
        if (found) grant[gsel] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_OPEN: begin
        if (LOCK != 0 && xfer && !in_last[gsel]) begin
          state_d = ST_LOCKED;
          lk_d    = gsel;
        end
      end
      ST_LOCKED: begin
        if (xfer && in_last[gsel]) state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
    if (RR != 0 && xfer && last_eff)
      ptr_d = (gsel == LAST_CH) ? '0 : gsel + SEL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OPEN;
      lk_q      <= '0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gsel];
        out_last  <= last_eff;
        out_sel   <= gsel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_muxn_rr.sv
// Bench for stream_muxn_rr: a round-robin/locking instance and a fixed-priority/unlocked
// instance share stimulus and are each compared against a cycle-level reference model.
module tb_stream_muxn_rr;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_last;
  logic           out_ready;
  logic [N-1:0]   rdy0, rdy1;
  logic [W-1:0]   od0, od1;
  logic           ol0, ol1, ov0, ov1;
  logic [1:0]     os0, os1;

  stream_muxn_rr #(.n(W), .N_CH(N), .RR(1), .LOCK(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy0), .out_data(od0), .out_last(ol0), .out_sel(os0), .out_valid(ov0),
    .out_ready(out_ready));

  stream_muxn_rr #(.n(W), .N_CH(N), .RR(0), .LOCK(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy1), .out_data(od1), .out_last(ol1), .out_sel(os1), .out_valid(ov1),
    .out_ready(out_ready));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state, index 0 = RR/LOCK instance, 1 = fixed/unlocked instance
  bit       cfg_rr [2] = '{1'b1, 1'b0};
  bit       cfg_lk [2] = '{1'b1, 1'b0};
  int       m_ptr [2], m_lkch [2], m_os [2], m_g [2];
  bit       m_lock [2], m_ov [2], m_ol [2];
  logic [W-1:0] m_od [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_ptr[c] = 0; m_lkch[c] = 0; m_os[c] = 0; m_g[c] = -1;
      m_lock[c] = 0; m_ov[c] = 0; m_ol[c] = 0; m_od[c] = '0;
    end
  endtask

  task automatic model_grant();
    for (int c = 0; c < 2; c++) begin
      m_g[c] = -1;
      if (!m_ov[c] || out_ready) begin
        if (cfg_lk[c] && m_lock[c]) begin
          if (in_valid[m_lkch[c]]) m_g[c] = m_lkch[c];
        end else begin
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = cfg_rr[c] ? (m_ptr[c] + k) % N : k;
            if (m_g[c] < 0 && in_valid[idx]) m_g[c] = idx;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < 2; c++) begin
      if (m_g[c] >= 0) begin
        int g;
        bit last;
        g = m_g[c];
        last = cfg_lk[c] ? in_last[g] : 1'b1;
        m_od[c] = in_data[g*W +: W];
        m_ol[c] = last;
        m_os[c] = g;
        m_ov[c] = 1'b1;
        if (cfg_rr[c] && last) m_ptr[c] = (g + 1) % N;
        if (cfg_lk[c]) begin
          m_lock[c] = !in_last[g];
          m_lkch[c] = g;
        end
      end else if (out_ready) begin
        m_ov[c] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check("out_valid_rr", 32'(ov0), 32'(m_ov[0]));
    check("out_data_rr",  32'(od0), 32'(m_od[0]));
    check("out_last_rr",  32'(ol0), 32'(m_ol[0]));
    check("out_sel_rr",   32'(os0), 32'(m_os[0]));
    check("out_valid_fp", 32'(ov1), 32'(m_ov[1]));
    check("out_data_fp",  32'(od1), 32'(m_od[1]));
    check("out_last_fp",  32'(ol1), 32'(m_ol[1]));
    check("out_sel_fp",   32'(os1), 32'(m_os[1]));
  endtask

  task automatic check_ready();
    check("in_ready_rr", 32'(rdy0), (m_g[0] >= 0) ? (32'd1 << m_g[0]) : 32'd0);
    check("in_ready_fp", 32'(rdy1), (m_g[1] >= 0) ? (32'd1 << m_g[1]) : 32'd0);
  endtask

  // mode 0: random, 1: all valid single-beat packets, 2: ch2 packet with a gap vs ch0
  task automatic drive(input int mode, input int s);
    case (mode)
      1: begin
        in_valid = '1; in_last = '1; out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'hA000 + 16'(i);
      end
      2: begin
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'($urandom);
        case (s)
          0:       begin in_valid = 4'b0100; in_last = 4'b0000; end
          1:       begin in_valid = 4'b0001; in_last = 4'b0001; end
          2:       begin in_valid = 4'b0101; in_last = 4'b0001; end
          3:       begin in_valid = 4'b0101; in_last = 4'b0101; end
          default: begin in_valid = 4'b0001; in_last = 4'b0001; end
        endcase
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          in_valid[i] = ($urandom_range(0, 9) < 7);
          in_last[i]  = ($urandom_range(0, 2) == 0);
          in_data[i*W +: W] = 16'($urandom);
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  task automatic step(input int mode, input int s);
    @(negedge clk);
    check_outputs();
    if (mode == 1 && s > 0) begin
      check("rr_seq_sel",  32'(os0), 32'((s - 1) % N));
      check("rr_seq_data", 32'(od0), 32'(16'hA000 + 16'((s - 1) % N)));
    end
    if (mode == 2) begin
      if (s == 2) check("lock_bubble", 32'(ov0), 32'd0);
      if (s == 3 || s == 4) check("lock_sel", 32'(os0), 32'd2);
      if (s == 5) check("after_pkt_sel", 32'(os0), 32'd0);
    end
    drive(mode, s);
    #1;
    model_grant();
    check_ready();
    model_update();
  endtask

  initial begin
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    in_valid = '1;
    out_ready = 1'b1;
    #1;
    check("rst_ready_rr", 32'(rdy0), 32'd0);
    check("rst_ready_fp", 32'(rdy1), 32'd0);
    check_outputs();
    in_valid = '0;
    rst_n = 1'b1;

    for (int s = 0; s < 12; s++) step(1, s);
    for (int s = 0; s < 3000; s++) step(0, s);

    // Asynchronous reset in the middle of a stream with a beat held
    in_valid = '1; in_last = '0; out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ov0), 32'd0);
    check("async_rst_data",  32'(od0), 32'd0);
    check("async_rst_ready", 32'(rdy0), 32'd0);
    check("async_rst_valid_fp", 32'(ov1), 32'd0);
    check("async_rst_ready_fp", 32'(rdy1), 32'd0);
    model_reset();
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 8; s++) step(2, s);
    for (int s = 0; s < 1000; s++) step(0, s);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_muxn_rr.md
Name: stream_muxn_rr

Overview:
- N-channel, n-bit registered stream multiplexer with valid/ready handshakes on every port.
- Selection is by internal arbitration (round-robin or fixed priority), not by an external select line.
- Optional packet lock holds the grant from first beat to last beat.
- Sits between multiple producers (e.g. memory/IO requesters) and one shared consumer; one registered output stage, full throughput.

Parameters:
- n, 16, data width per channel.
- N_CH, 4, number of input channels (>=1).
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority, channel 0 highest.
- LOCK, 1, 1 = grant held for the whole packet (until in_last beat); 0 = re-arbitrate every beat.
- SEL_W, localparam, max(1, $clog2(N_CH)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_CH*n  packed channel data; channel i = bits [i*n +: n].
- in_valid  input  N_CH  per-channel valid.
- in_last  input  N_CH  per-channel end-of-packet flag (ignored when LOCK=0).
- in_ready  output  N_CH  per-channel ready (combinational).
- out_data  output  n  registered data.
- out_last  output  1  registered last flag of the held beat.
- out_sel  output  SEL_W  index of the channel that supplied the held beat.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=0, out_last=0, out_sel=0, priority pointer ptr=0, lock=0. in_ready=0 while rst_n=0.
- load = !out_valid | out_ready. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- Grant (combinational, only when load=1):
  - lock=1: only the locked channel lk is eligible.
  - RR=1, unlocked: first valid channel searching ptr, ptr+1, ..., wrapping at N_CH.
  - RR=0, unlocked: lowest-index valid channel.
- in_ready[i] = load & grant[i]. At most one bit set, so the grant is one-hot.
- On transfer from channel g, at the next edge:
  - out_data = in_data[g]; out_last = in_last[g] (forced 1 when LOCK=0); out_sel = g; out_valid = 1.
- Output drained with no transfer that cycle (out_valid & out_ready, no grant): out_valid -> 0.
- out_valid=1 & out_ready=0: out_data, out_last, out_sel held stable; in_ready all 0.
- Latency: 1 cycle input->output. Throughput: 1 beat/cycle with out_ready held high.
- Pointer: RR=1 and a transfer with effective last=1 -> ptr = (g+1) mod N_CH. Otherwise ptr unchanged. RR=0: ptr stays 0.
- Lock (LOCK=1): a transfer with in_last[g]=0 sets lock=1, lk=g. A transfer from lk with in_last=1 clears lock.
- Locked channel drops valid mid-packet: no grant that cycle; output bubbles; other channels stay stalled until the packet ends.
- N_CH=1: grant = in_valid[0] & load; out_sel=0 always.
- Reset asserted mid-packet: lock and ptr cleared immediately; the held beat is discarded (out_valid=0).
- No combinational path from in_valid to out_*. in_ready depends on out_ready (combinational pass-through).

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, in_ready=0 immediately, asynchronous to clk.
- RR fairness: N_CH=4, all valid, in_last=1, out_ready=1 -> out_sel sequence 0,1,2,3,0,...; in_data[i]=16'hA000+i appears 1 cycle after grant.
- Backpressure: out_ready=0 for 3 cycles with beat 16'h1234 held -> out_data stable 16'h1234, in_ready=4'b0000. out_ready=1 -> next beat loads same cycle, no gap.
- Packet lock: ch2 sends 3 beats (last on 3rd), ch0 valid throughout -> out_sel=2,2,2 then 0; ptr=3 after packet. A ch2 valid gap of 1 cycle -> one bubble, ch0 not granted.
- Fixed priority: RR=0, ch1 and ch3 valid continuously -> ch1 granted every beat; ch3 granted only when ch1 drops valid.
- LOCK=0: ch0 beat with in_last=0, ch1 valid -> next grant goes to ch1; out_last=1 on every beat.
